branch_resolve_unit: RTL and testbench
======================================

# branch_resolve_unit

Decode-side counterpart of the global branch predictor. It queues every prediction fetch makes and checks each one against the actual outcome when that instruction resolves in decode. On a wrong prediction it issues a registered redirect, `clrbp` and a predictor-table update. It sits between the fetch-stage predictor (producer of predictions) and the decode-stage branch logic (producer of `pcsrcd`/`pcbranchd`).

## Interface
- `DEPTH`, 4 — prediction queue entries; power of two, at least 2.
- `CNTW`, 16 — width of the mispredict counter.

- `clk` in 1 — clock, rising edge.
- `reset_n` in 1 — asynchronous, active-low reset.
- `pred_valid` in 1 — fetch issued a prediction this cycle (push).
- `pred_pc` in 32 — PC of the fetched instruction.
- `pred_taken` in 1 — predictor said taken.
- `pred_target` in 32 — predicted next PC.
- `res_valid` in 1 — decode resolves the oldest queued instruction (pop).
- `pcd` in 32 — PC of the resolving instruction.
- `pcsrcd` in 2 — actual outcome; bit 0 = taken.
- `pcbranchd` in 32 — actual branch target.
- `redirect` out 1 — one-cycle pulse: fetch must load `redirect_pc`.
- `redirect_pc` out 32 — correct next PC.
- `clrbp` out 1 — one-cycle pulse: flush wrong-path fetch/decode; equals `redirect`.
- `upd_valid` out 1 — one-cycle pulse: write the predictor table.
- `upd_pc` out 32 — PC being trained.
- `upd_taken` out 1 — actual direction.
- `upd_target` out 32 — actual target.
- `full` out 1 — queue full.
- `empty` out 1 — queue empty.
- `mispredicts` out CNTW — saturating count of redirects.

## Operation
- **Queue:** a FIFO of `{pc, taken, target}`, `DEPTH` entries, with wrapping read/write pointers plus an occupancy count.
- **Push:** `pred_valid & ~full`. A push while full is dropped.
- **Pop:** `res_valid & ~empty`. With `res_valid` while empty, the queue is unchanged and no output pulses.
- **Actual next PC:** `pcsrcd[0] ? pcbranchd : pcd + 32'd4`, computed modulo 2^32 (wraps).
- **Mispredict on pop:** any one of the following:
  - `head.taken != pcsrcd[0]`;
  - `head.taken & pcsrcd[0] & head.target != pcbranchd`;
  - `head.pc != pcd` (sequence loss).
- **On mispredict:**
  - `redirect` and `clrbp` are asserted for one cycle.
  - `redirect_pc` = actual next PC.
  - The whole queue is flushed to empty, because every younger entry is wrong-path. A push in the same cycle is discarded.
  - `mispredicts` increments, saturating at all-ones.
- **Training:** on any pop where `head.taken | pcsrcd[0]`:
  - `upd_valid` = 1, `upd_pc` = `pcd`, `upd_taken` = `pcsrcd[0]`, `upd_target` = `pcbranchd`.
  - This also happens on correct predictions, to refresh the entry.
- **Correct prediction:** pop only; no redirect.
- **Simultaneous push and pop, no mispredict:** both take effect. When full, the pop frees a slot, so the push is accepted and occupancy is unchanged.

## Timing
- All outputs are registered.
- Resolution at edge N (`res_valid` sampled) gives `redirect`/`clrbp`/`upd_*` valid during cycle N+1, for exactly one cycle.
- `redirect_pc` and `upd_*` data hold their last values when not pulsing.
- `full`/`empty` reflect occupancy after edge N, during cycle N+1.
- Queue flush takes effect at edge N. A push at edge N+1 is accepted normally; fetch is expected to gate `pred_valid` with `clrbp`.
- **Reset (`reset_n` low, asynchronous, at any time, including mid-resolve):**
  - Outputs `redirect`, `clrbp` and `upd_valid` = 0.
  - Outputs `redirect_pc`, `upd_pc` and `upd_target` = 0.
  - Output `upd_taken` = 0, `full` = 0, `empty` = 1, `mispredicts` = 0.
  - Internal state: pointers and count = 0.
  - Pending pulses are lost.
- **Release:** deassertion is sampled at the next rising edge; first push is possible at that edge.

## Test plan
- **Correct not-taken:**
  - Stimulus: push `{pc=0x1, nt}`, then resolve `pcd=0x1`, `pcsrcd=00`.
  - Required: no redirect, `upd_valid`=0, `empty`=1.
- **Predicted not-taken, actually taken:**
  - Stimulus: push `{0x3, nt}` and `{0x4, nt}`; resolve `pcd=0x3`, `pcsrcd=01`, `pcbranchd=0x50`.
  - Required: next cycle `redirect`=`clrbp`=1, `redirect_pc`=0x50; `upd_valid`=1, `upd_pc`=0x3, `upd_target`=0x50; queue empty (0x4 flushed); `mispredicts`=1.
- **Predicted taken, actually not-taken:**
  - Stimulus: push `{0x50, t, 0x10}`; resolve `pcd=0x50`, `pcsrcd=00`.
  - Required: `redirect_pc`=0x54, `upd_taken`=0.
- **Correct taken, target mismatch:**
  - Stimulus: push `{0x23, t, 0x88}`; resolve `pcsrcd=01`, `pcbranchd=0x24`.
  - Required: redirect to 0x24.
  - Stimulus, repeated with a matching target 0x88.
  - Required: `upd_valid`=1, no redirect.
- **Full boundary:**
  - Stimulus: 4 pushes.
  - Required: `full`=1; a 5th push is dropped.
  - Stimulus: push together with a correct pop.
  - Required: `full` stays 1; FIFO order is preserved across pointer wrap (pops return 2nd, 3rd, 4th, 5th PCs).
- **Reset mid-operation, and wrap/saturate:**
  - Stimulus: assert `reset_n`=0 asynchronously with 3 entries queued and a mispredict pending.
  - Required: `redirect`=0 immediately, `empty`=1, `mispredicts`=0.
  - Stimulus: `pcd=0xFFFFFFFC` not-taken mispredict.
  - Required: `redirect_pc`=0x0.
  - Stimulus: with `CNTW=2`, 5 mispredicts.
  - Required: `mispredicts`=3.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Decode-side branch resolution: queues fetch predictions, checks each one
// against the actual outcome when it resolves, and on a wrong prediction
// issues a registered redirect, a pipeline clear and a predictor update.
//
// Handshake: a prediction is accepted when pred_valid is high and a slot is
// free (a slot freed by a same-cycle correct pop counts). A resolution is
// consumed when res_valid is high and the queue is not empty. Neither side
// is back-pressured; a push while full is silently dropped, and res_valid
// while empty is ignored.
module branch_resolve_unit #(
    parameter int DEPTH = 4,
    parameter int CNTW  = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            pred_valid,
    input  logic [31:0]     pred_pc,
    input  logic            pred_taken,
    input  logic [31:0]     pred_target,
    input  logic            res_valid,
    input  logic [31:0]     pcd,
    input  logic [1:0]      pcsrcd,
    input  logic [31:0]     pcbranchd,
    output logic            redirect,
    output logic [31:0]     redirect_pc,
    output logic            clrbp,
    output logic            upd_valid,
    output logic [31:0]     upd_pc,
    output logic            upd_taken,
    output logic [31:0]     upd_target,
    output logic            full,
    output logic            empty,
    output logic [CNTW-1:0] mispredicts
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   q_pc     [DEPTH];
    logic          q_taken  [DEPTH];
    logic [31:0]   q_target [DEPTH];

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic          pop;
    logic          push;
    logic          mis;
    logic          train;
    logic          slot_free;
    logic [31:0]   head_pc;
    logic          head_taken;
    logic [31:0]   head_target;
    logic [31:0]   next_pc;
    logic [CW-1:0] count_nxt;

    // Only bit 0 of pcsrcd carries the direction; bit 1 is not used here.
    logic          unused_pcsrcd_hi;
    assign unused_pcsrcd_hi = pcsrcd[1];

    // Compare the head entry with the resolving instruction and plan queue moves.
    always_comb begin
        head_pc     = q_pc[rd_ptr];
        head_taken  = q_taken[rd_ptr];
        head_target = q_target[rd_ptr];
        next_pc     = pcsrcd[0] ? pcbranchd : pcd + 32'd4;
        pop         = res_valid && (count != '0);
        mis         = pop && ((head_taken != pcsrcd[0]) ||
                              (head_taken && pcsrcd[0] && (head_target != pcbranchd)) ||
                              (head_pc != pcd));
        train       = pop && (head_taken || pcsrcd[0]);
        slot_free   = (count != CW'(DEPTH)) || pop;
        // A mispredict flushes everything younger, including a same-cycle push.
        push        = pred_valid && slot_free && !mis;
        if (mis)
            count_nxt = '0;
        else
            count_nxt = count + CW'(push) - CW'(pop);
    end

    // Queue storage; only written on an accepted push, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]     <= pred_pc;
            q_taken[wr_ptr]  <= pred_taken;
            q_target[wr_ptr] <= pred_target;
        end
    end

    // Pointers, occupancy flags, redirect/update pulses and mispredict counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            full        <= 1'b0;
            empty       <= 1'b1;
            redirect    <= 1'b0;
            clrbp       <= 1'b0;
            redirect_pc <= '0;
            upd_valid   <= 1'b0;
            upd_pc      <= '0;
            upd_taken   <= 1'b0;
            upd_target  <= '0;
            mispredicts <= '0;
        end else begin
            if (mis) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
                if (push)
                    wr_ptr <= wr_ptr + PW'(1);
            end
            count    <= count_nxt;
            full     <= (count_nxt == CW'(DEPTH));
            empty    <= (count_nxt == '0);
            redirect <= mis;
            clrbp    <= mis;
            if (mis)
                redirect_pc <= next_pc;
            upd_valid <= train;
            if (train) begin
                upd_pc     <= pcd;
                upd_taken  <= pcsrcd[0];
                upd_target <= pcbranchd;
            end
            if (mis && (mispredicts != '1))
                mispredicts <= mispredicts + CNTW'(1);
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: a behavioural model predicts
// every registered output per cycle, expected records are queued when the
// stimulus is driven and popped once the DUT has registered the result.
module tb_branch_resolve_unit;

    typedef struct packed {
        logic        pv;
        logic [31:0] ppc;
        logic        pt;
        logic [31:0] ptg;
        logic        rv;
        logic [31:0] rpc;
        logic [1:0]  src;
        logic [31:0] br;
    } stim_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } ent_t;

    typedef struct packed {
        logic        redirect;
        logic        clrbp;
        logic [31:0] redirect_pc;
        logic        upd_valid;
        logic [31:0] upd_pc;
        logic        upd_taken;
        logic [31:0] upd_target;
        logic        full;
        logic        empty;
        logic [15:0] mispredicts;
        logic [1:0]  mis_small;
    } out_t;

    // ---------------- clock / reset / DUT ----------------
    logic        clk;
    logic        reset_n;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        res_valid;
    logic [31:0] pcd;
    logic [1:0]  pcsrcd;
    logic [31:0] pcbranchd;
    logic        redirect, clrbp, upd_valid, upd_taken, full, empty;
    logic [31:0] redirect_pc, upd_pc, upd_target;
    logic [15:0] mispredicts;
    logic        s_redirect, s_clrbp, s_upd_valid, s_upd_taken, s_full, s_empty;
    logic [31:0] s_redirect_pc, s_upd_pc, s_upd_target;
    logic [1:0]  s_mispredicts;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    branch_resolve_unit #(.DEPTH(4), .CNTW(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken),
        .pred_target(pred_target), .res_valid(res_valid), .pcd(pcd),
        .pcsrcd(pcsrcd), .pcbranchd(pcbranchd),
        .redirect(redirect), .redirect_pc(redirect_pc), .clrbp(clrbp),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .full(full), .empty(empty),
        .mispredicts(mispredicts)
    );

    // Narrow-counter copy sharing the same stimulus, to exercise saturation.
    branch_resolve_unit #(.DEPTH(4), .CNTW(2)) dut_small (
        .clk(clk), .reset_n(reset_n),
        .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken),
        .pred_target(pred_target), .res_valid(res_valid), .pcd(pcd),
        .pcsrcd(pcsrcd), .pcbranchd(pcbranchd),
        .redirect(s_redirect), .redirect_pc(s_redirect_pc), .clrbp(s_clrbp),
        .upd_valid(s_upd_valid), .upd_pc(s_upd_pc), .upd_taken(s_upd_taken),
        .upd_target(s_upd_target), .full(s_full), .empty(s_empty),
        .mispredicts(s_mispredicts)
    );

    // ---------------- model / scoreboard ----------------
    ent_t        mq[$];
    out_t        exp_q[$];
    logic [31:0] m_rpc, m_upc, m_utg;
    logic        m_ut;
    int unsigned m_cnt, m_small;
    int          n_vec = 0;
    int          n_err = 0;

    function automatic out_t observe();
        return {redirect, clrbp, redirect_pc, upd_valid, upd_pc, upd_taken,
                upd_target, full, empty, mispredicts, s_mispredicts};
    endfunction

    function automatic stim_t st(input logic pv, input logic [31:0] ppc,
                                 input logic pt, input logic [31:0] ptg,
                                 input logic rv, input logic [31:0] rpc,
                                 input logic [1:0] src, input logic [31:0] br);
        return {pv, ppc, pt, ptg, rv, rpc, src, br};
    endfunction

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        m_rpc = '0; m_upc = '0; m_utg = '0; m_ut = 1'b0;
        m_cnt = 0; m_small = 0;
    endtask

    // ---------------- driver ----------------
    // Drives one cycle of stimulus, queues the model's expectation for the
    // outputs registered at that edge, and returns 1 ns after the edge.
    task automatic step(input stim_t s);
        ent_t        h;
        bit          pop, mis, upd, push;
        logic [31:0] npc;
        out_t        e;
        pred_valid  = s.pv;  pred_pc = s.ppc; pred_taken = s.pt; pred_target = s.ptg;
        res_valid   = s.rv;  pcd = s.rpc; pcsrcd = s.src; pcbranchd = s.br;
        pop = s.rv && (mq.size() != 0);
        mis = 1'b0; upd = 1'b0; npc = '0; h = '0;
        if (pop) begin
            h   = mq[0];
            npc = s.src[0] ? s.br : s.rpc + 32'd4;
            mis = (h.taken != s.src[0]) || (h.taken && s.src[0] && h.target != s.br) ||
                  (h.pc != s.rpc);
            upd = h.taken || s.src[0];
        end
        push = s.pv && !mis && ((mq.size() < 4) || pop);
        if (pop) void'(mq.pop_front());
        if (mis) mq.delete();
        if (push) mq.push_back({s.ppc, s.pt, s.ptg});
        if (mis) begin
            m_rpc = npc;
            if (m_cnt < 16'hFFFF) m_cnt++;
            if (m_small < 3) m_small++;
        end
        if (upd) begin
            m_upc = s.rpc; m_ut = s.src[0]; m_utg = s.br;
        end
        e = {mis, mis, m_rpc, upd, m_upc, m_ut, m_utg, (mq.size() == 4), (mq.size() == 0),
             m_cnt[15:0], m_small[1:0]};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        pred_valid = 1'b0;
        res_valid  = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        out_t r;
        pred_valid = 0; pred_pc = 0; pred_taken = 0; pred_target = 0;
        res_valid = 0; pcd = 0; pcsrcd = 0; pcbranchd = 0;
        reset_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        r = '0; r.empty = 1'b1;
        n_vec++;
        if (observe() !== r) begin
            n_err++;
            $display("FAIL reset_state got %h exp %h", observe(), r);
        end
        reset_n = 1'b1;
    endtask

    task automatic run_tbl(input string name, input stim_t v[$]);
        out_t e;
        foreach (v[i]) begin
            step(v[i]);
            e = exp_q.pop_front();
            n_vec++;
            if (observe() !== e) begin
                n_err++;
                $display("FAIL %s[%0d] got %h exp %h", name, i, observe(), e);
            end
        end
    endtask

    task automatic test_correct_nt();
        stim_t v[$];
        v.push_back(st(1, 32'h1, 0, 32'h0, 0, 0, 2'b00, 0));
        v.push_back(st(0, 0, 0, 0, 1, 32'h1, 2'b00, 32'h0));
        run_tbl("correct_nt", v);
        n_vec++;
        if ({redirect, upd_valid, empty} !== 3'b001) begin
            n_err++;
            $display("FAIL correct_nt_flags got %b exp 001", {redirect, upd_valid, empty});
        end
    endtask

    task automatic test_nt_taken();
        stim_t v[$];
        v.push_back(st(1, 32'h3, 0, 32'h0, 0, 0, 2'b00, 0));
        v.push_back(st(1, 32'h4, 0, 32'h0, 0, 0, 2'b00, 0));
        v.push_back(st(0, 0, 0, 0, 1, 32'h3, 2'b01, 32'h50));
        run_tbl("nt_taken", v);
        n_vec++;
        if ({redirect, clrbp, redirect_pc, upd_valid, upd_pc, upd_target, empty, mispredicts}
            !== {1'b1, 1'b1, 32'h50, 1'b1, 32'h3, 32'h50, 1'b1, 16'd1}) begin
            n_err++;
            $display("FAIL nt_taken_fields got rd=%b pc=%h upd_pc=%h tgt=%h empty=%b cnt=%0d",
                     redirect, redirect_pc, upd_pc, upd_target, empty, mispredicts);
        end
    endtask

    task automatic test_t_nt();
        stim_t v[$];
        v.push_back(st(1, 32'h50, 1, 32'h10, 0, 0, 2'b00, 0));
        v.push_back(st(0, 0, 0, 0, 1, 32'h50, 2'b00, 32'h10));
        run_tbl("t_nt", v);
        n_vec++;
        if ({redirect, redirect_pc, upd_valid, upd_taken} !== {1'b1, 32'h54, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL t_nt_fields got rd=%b pc=%h uv=%b ut=%b exp 1 00000054 1 0",
                     redirect, redirect_pc, upd_valid, upd_taken);
        end
    endtask

    task automatic test_target();
        stim_t v[$];
        stim_t w[$];
        v.push_back(st(1, 32'h23, 1, 32'h88, 0, 0, 2'b00, 0));
        v.push_back(st(0, 0, 0, 0, 1, 32'h23, 2'b01, 32'h24));
        run_tbl("target_mismatch", v);
        n_vec++;
        if ({redirect, redirect_pc} !== {1'b1, 32'h24}) begin
            n_err++;
            $display("FAIL target_mismatch_pc got %b %h exp 1 00000024", redirect, redirect_pc);
        end
        w.push_back(st(1, 32'h23, 1, 32'h88, 0, 0, 2'b00, 0));
        w.push_back(st(0, 0, 0, 0, 1, 32'h23, 2'b11, 32'h88));
        run_tbl("target_match", w);
        n_vec++;
        if ({redirect, upd_valid, upd_target} !== {1'b0, 1'b1, 32'h88}) begin
            n_err++;
            $display("FAIL target_match_upd got rd=%b uv=%b tgt=%h exp 0 1 00000088",
                     redirect, upd_valid, upd_target);
        end
    endtask

    task automatic test_full();
        stim_t v[$];
        stim_t w[$];
        for (int i = 0; i < 4; i++)
            v.push_back(st(1, 32'h100 + 32'(4 * i), 0, 32'h0, 0, 0, 2'b00, 0));
        run_tbl("full_fill", v);
        n_vec++;
        if (full !== 1'b1) begin
            n_err++;
            $display("FAIL full_flag got %b exp 1", full);
        end
        w.push_back(st(1, 32'h110, 0, 32'h0, 0, 0, 2'b00, 0));          // dropped
        w.push_back(st(1, 32'h114, 0, 32'h0, 1, 32'h100, 2'b00, 0));    // push + pop
        run_tbl("full_pushpop", w);
        n_vec++;
        if (full !== 1'b1) begin
            n_err++;
            $display("FAIL full_after_pushpop got %b exp 1", full);
        end
        w.delete();
        w.push_back(st(0, 0, 0, 0, 1, 32'h104, 2'b00, 0));
        w.push_back(st(0, 0, 0, 0, 1, 32'h108, 2'b00, 0));
        w.push_back(st(0, 0, 0, 0, 1, 32'h10C, 2'b00, 0));
        w.push_back(st(0, 0, 0, 0, 1, 32'h114, 2'b00, 0));
        run_tbl("full_drain_order", w);
        n_vec++;
        if ({redirect, empty} !== 2'b01) begin
            n_err++;
            $display("FAIL drain_order got rd=%b empty=%b exp 0 1", redirect, empty);
        end
    endtask

    task automatic test_empty_resolve();
        stim_t v[$];
        v.push_back(st(0, 0, 0, 0, 1, 32'h40, 2'b01, 32'h80));
        v.push_back(st(0, 0, 0, 0, 1, 32'h44, 2'b00, 32'h0));
        run_tbl("empty_resolve", v);
    endtask

    task automatic test_back_to_back();
        stim_t v[$];
        v.push_back(st(1, 32'h200, 1, 32'h300, 0, 0, 2'b00, 0));
        v.push_back(st(1, 32'h300, 0, 32'h0, 1, 32'h200, 2'b01, 32'h300));
        v.push_back(st(1, 32'h304, 1, 32'h400, 1, 32'h300, 2'b00, 0));
        v.push_back(st(1, 32'h400, 0, 32'h0, 1, 32'h304, 2'b01, 32'h404)); // mispredict, push lost
        v.push_back(st(1, 32'h404, 0, 32'h0, 0, 0, 2'b00, 0));             // accepted after flush
        v.push_back(st(0, 0, 0, 0, 1, 32'h404, 2'b00, 0));
        run_tbl("back_to_back", v);
    endtask

    task automatic test_reset_mid();
        stim_t v[$];
        v.push_back(st(1, 32'h600, 0, 0, 0, 0, 2'b00, 0));
        v.push_back(st(1, 32'h604, 0, 0, 0, 0, 2'b00, 0));
        v.push_back(st(1, 32'h608, 0, 0, 0, 0, 2'b00, 0));
        v.push_back(st(1, 32'h60C, 0, 0, 1, 32'h600, 2'b01, 32'h700));
        run_tbl("reset_mid_setup", v);
        #2;
        reset_n = 1'b0;
        #1;
        n_vec++;
        if ({redirect, clrbp, upd_valid, empty, mispredicts} !== {4'b0001, 16'd0}) begin
            n_err++;
            $display("FAIL reset_async got rd=%b clr=%b uv=%b empty=%b cnt=%0d exp 0 0 0 1 0",
                     redirect, clrbp, upd_valid, empty, mispredicts);
        end
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_wrap_saturate();
        stim_t v[$];
        v.push_back(st(1, 32'hFFFF_FFFC, 1, 32'h100, 0, 0, 2'b00, 0));
        v.push_back(st(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 2'b00, 0));
        run_tbl("pc_wrap", v);
        n_vec++;
        if ({redirect, redirect_pc} !== {1'b1, 32'h0}) begin
            n_err++;
            $display("FAIL pc_wrap got rd=%b pc=%h exp 1 00000000", redirect, redirect_pc);
        end
        v.delete();
        for (int i = 0; i < 4; i++) begin
            v.push_back(st(1, 32'h800 + 32'(i * 16), 0, 32'h0, 0, 0, 2'b00, 0));
            v.push_back(st(0, 0, 0, 0, 1, 32'h800 + 32'(i * 16), 2'b01, 32'h900));
        end
        run_tbl("saturate", v);
        n_vec++;
        if ({mispredicts, s_mispredicts} !== {16'd5, 2'd3}) begin
            n_err++;
            $display("FAIL saturate_cnt got %0d/%0d exp 5/3", mispredicts, s_mispredicts);
        end
    endtask

    task automatic test_random();
        stim_t v[$];
        stim_t s;
        out_t  e;
        for (int i = 0; i < 400; i++) begin
            s = st($urandom_range(0, 1), 32'($urandom_range(0, 255)) << 2, $urandom_range(0, 1),
                   $urandom(), $urandom_range(0, 2) != 0, $urandom() & 32'h3FC,
                   2'($urandom_range(0, 3)), $urandom());
            if (mq.size() != 0 && $urandom_range(0, 7) != 0) begin
                s.rpc = mq[0].pc;
                s.src[0] = mq[0].taken;
                if (mq[0].taken) s.br = mq[0].target;
            end
            step(s);
            e = exp_q.pop_front();
            n_vec++;
            if (observe() !== e) begin
                n_err++;
                $display("FAIL random[%0d] got %h exp %h", i, observe(), e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_correct_nt();
        test_nt_taken();
        test_t_nt();
        test_target();
        test_full();
        test_empty_resolve();
        test_back_to_back();
        test_reset_mid();
        test_wrap_saturate();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
